ysyx_24100006_axi_sram_slave: RTL and testbench

YSYX_24100006_AXI_SRAM_SLAVE -- requirements
Module: ysyx_24100006_axi_sram_slave

---
 rtl/ysyx_24100006_axi_sram_slave_pkg.sv | 29 ++
 rtl/ysyx_24100006_axi_sram_slave_if.sv | 43 ++++
 rtl/ysyx_24100006_lfsr16.sv | 29 ++
 rtl/ysyx_24100006_axi_sram_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_sram_slave.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100006_axi_sram_slave_pkg.sv
// Shared constants and FSM encodings for the AXI SRAM slave.
package ysyx_24100006_axi_sram_slave_pkg;

    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_DW = 32;
    localparam int unsigned AXI_LW = 8;
    localparam int unsigned AXI_SW = AXI_DW / 8;
    localparam int unsigned DLY_W  = 3;
    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DATA  = 2'd1,
        W_DELAY = 2'd2,
        W_RESP  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/ysyx_24100006_axi_sram_slave_if.sv
// AXI read/write channel bundle between a master and the SRAM slave.
interface ysyx_24100006_axi_sram_slave_if;
    import ysyx_24100006_axi_sram_slave_pkg::*;

    logic              axi_arvalid;
    logic              axi_arready;
    logic [AXI_AW-1:0] axi_araddr;
    logic [AXI_LW-1:0] axi_arlen;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [AXI_DW-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [AXI_AW-1:0] axi_awaddr;
    logic [AXI_LW-1:0] axi_awlen;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [AXI_DW-1:0] axi_wdata;
    logic [AXI_SW-1:0] axi_wstrb;
    logic              axi_wlast;
    logic              axi_bvalid;
    logic              axi_bready;
    logic [1:0]        axi_bresp;

    modport master (
        output axi_arvalid, axi_araddr, axi_arlen, axi_rready,
        output axi_awvalid, axi_awaddr, axi_awlen,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

    modport slave (
        input  axi_arvalid, axi_araddr, axi_arlen, axi_rready,
        input  axi_awvalid, axi_awaddr, axi_awlen,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

endinterface

// File: rtl/ysyx_24100006_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) supplying
// random read/write response delays.
module ysyx_24100006_lfsr16
    import ysyx_24100006_axi_sram_slave_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [DLY_W-1:0] o_rd_dly,
    output logic [DLY_W-1:0] o_wr_dly
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    // Disjoint bit fields so read and write delays are not identical.
    assign o_rd_dly = r_lfsr[2:0];
    assign o_wr_dly = r_lfsr[5:3];

endmodule

// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI INCR-burst SRAM slave with independent read and write FSMs.
// YSYX_24100006_SRAM_RAND_DELAY_EN enables LFSR-driven random response delays.
module ysyx_24100006_axi_sram_slave
    import ysyx_24100006_axi_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset,
    ysyx_24100006_axi_sram_slave_if.slave        axi
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);

    logic [AXI_DW-1:0] r_mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [AXI_AW-1:0] a);
        return (33'(a) >= 33'(BASE_ADDR)) && (33'(a) < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_AW-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [DLY_W-1:0] w_rdly_seed;
    logic [DLY_W-1:0] w_wdly_seed;

`ifdef YSYX_24100006_SRAM_RAND_DELAY_EN
    ysyx_24100006_lfsr16 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .o_rd_dly (w_rdly_seed),
        .o_wr_dly (w_wdly_seed)
    );
`else
    assign w_rdly_seed = '0;
    assign w_wdly_seed = '0;
`endif

    // ---------------- read channel ----------------
    rd_state_e         r_rstate, w_rstate_nxt;
    logic [AXI_AW-1:0] r_raddr, w_raddr_nxt;
    logic [AXI_LW-1:0] r_rlen, w_rlen_nxt;
    logic [AXI_LW-1:0] r_rcnt, w_rcnt_nxt;
    logic [DLY_W-1:0]  r_rdly, w_rdly_nxt;
    logic              r_arready, w_arready_nxt;
    logic              r_rvalid, w_rvalid_nxt;
    logic [AXI_DW-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]        r_rresp, w_rresp_nxt;
    logic              r_rlast, w_rlast_nxt;
    logic              w_rd_ok;

    assign w_rd_ok = in_range(r_raddr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rdly    <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
            r_rlast   <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rdly    <= w_rdly_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rlast   <= w_rlast_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (axi.axi_arvalid) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_rdly == '0) w_rstate_nxt = R_DATA;
            R_DATA:  if (axi.axi_rready) w_rstate_nxt = r_rlast ? R_IDLE : R_WAIT;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Beat data is captured on entry to R_DATA and held until rready.
    always_comb begin
        w_raddr_nxt   = r_raddr;
        w_rlen_nxt    = r_rlen;
        w_rcnt_nxt    = r_rcnt;
        w_rdly_nxt    = r_rdly;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        w_rlast_nxt   = r_rlast;
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rstate_nxt == R_DATA);
        unique case (r_rstate)
            R_IDLE: begin
                if (axi.axi_arvalid) begin
                    w_raddr_nxt = axi.axi_araddr;
                    w_rlen_nxt  = axi.axi_arlen;
                    w_rcnt_nxt  = '0;
                    w_rdly_nxt  = w_rdly_seed;
                end
            end
            R_WAIT: begin
                if (r_rdly == '0) begin
                    w_rdata_nxt = w_rd_ok ? r_mem[word_idx(r_raddr)] : '0;
                    w_rresp_nxt = w_rd_ok ? OKAY : SLVERR;
                    w_rlast_nxt = (r_rcnt == r_rlen);
                end else begin
                    w_rdly_nxt = r_rdly - DLY_W'(1);
                end
            end
            R_DATA: begin
                if (axi.axi_rready) begin
                    w_rdata_nxt = '0;
                    w_rresp_nxt = OKAY;
                    w_rlast_nxt = 1'b0;
                    if (!r_rlast) begin
                        w_raddr_nxt = r_raddr + AXI_AW'(4);
                        w_rcnt_nxt  = r_rcnt + AXI_LW'(1);
                        w_rdly_nxt  = w_rdly_seed;
                    end
                end
            end
            default: ;
        endcase
    end

    assign axi.axi_arready = r_arready;
    assign axi.axi_rvalid  = r_rvalid;
    assign axi.axi_rdata   = r_rdata;
    assign axi.axi_rresp   = r_rresp;
    assign axi.axi_rlast   = r_rlast;

    // ---------------- write channel ----------------
    wr_state_e         r_wstate, w_wstate_nxt;
    logic [AXI_AW-1:0] r_waddr, w_waddr_nxt;
    logic [AXI_LW-1:0] r_wlen, w_wlen_nxt;
    logic [AXI_LW-1:0] r_wcnt, w_wcnt_nxt;
    logic [DLY_W-1:0]  r_wdly, w_wdly_nxt;
    logic              r_werr, w_werr_nxt;
    logic              r_awready, w_awready_nxt;
    logic              r_wready, w_wready_nxt;
    logic              r_bvalid, w_bvalid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
    logic              w_whs;
    logic              w_wr_ok;
    logic              w_beat_err;

    assign w_whs      = (r_wstate == W_DATA) && axi.axi_wvalid;
    assign w_wr_ok    = in_range(r_waddr);
    // wlast must coincide exactly with the awlen-th beat.
    assign w_beat_err = !w_wr_ok || (axi.axi_wlast != (r_wcnt == r_wlen));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wdly    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wlen    <= w_wlen_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_wdly    <= w_wdly_nxt;
            r_werr    <= w_werr_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (axi.axi_awvalid) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_whs && axi.axi_wlast)
                         w_wstate_nxt = (w_wdly_seed == '0) ? W_RESP : W_DELAY;
            W_DELAY: if (r_wdly <= DLY_W'(1)) w_wstate_nxt = W_RESP;
            W_RESP:  if (axi.axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_waddr_nxt   = r_waddr;
        w_wlen_nxt    = r_wlen;
        w_wcnt_nxt    = r_wcnt;
        w_wdly_nxt    = r_wdly;
        w_werr_nxt    = r_werr;
        w_awready_nxt = (w_wstate_nxt == W_IDLE);
        w_wready_nxt  = (w_wstate_nxt == W_DATA);
        w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
        unique case (r_wstate)
            W_IDLE: begin
                if (axi.axi_awvalid) begin
                    w_waddr_nxt = axi.axi_awaddr;
                    w_wlen_nxt  = axi.axi_awlen;
                    w_wcnt_nxt  = '0;
                    w_werr_nxt  = 1'b0;
                end
            end
            W_DATA: begin
                if (w_whs) begin
                    w_waddr_nxt = r_waddr + AXI_AW'(4);
                    w_wcnt_nxt  = r_wcnt + AXI_LW'(1);
                    w_werr_nxt  = r_werr | w_beat_err;
                    w_wdly_nxt  = w_wdly_seed;
                end
            end
            W_DELAY: w_wdly_nxt = r_wdly - DLY_W'(1);
            default: ;
        endcase
        w_bresp_nxt = (w_bvalid_nxt && w_werr_nxt) ? SLVERR : OKAY;
    end

    // Storage has no reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (!reset && w_whs && w_wr_ok) begin
            for (int b = 0; b < int'(AXI_SW); b++) begin
                if (axi.axi_wstrb[b]) begin
                    r_mem[word_idx(r_waddr)][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign axi.axi_awready = r_awready;
    assign axi.axi_wready  = r_wready;
    assign axi.axi_bvalid  = r_bvalid;
    assign axi.axi_bresp   = r_bresp;

endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Directed, table-driven bench for the AXI SRAM slave (default build).
module tb_ysyx_24100006_axi_sram_slave;

    localparam int TMO = 40;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    ysyx_24100006_axi_sram_slave_if ifc ();

    ysyx_24100006_axi_sram_slave #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_WORDS (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .axi   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] init;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: timeout after %0d cycles, expected handshake", name, TMO);
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len);
        int n = 0;
        ifc.axi_awvalid = 1'b1;
        ifc.axi_awaddr  = a;
        ifc.axi_awlen   = len;
        while (!ifc.axi_awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) timeout("aw");
        tick();
        ifc.axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        ifc.axi_wvalid = 1'b1;
        ifc.axi_wdata  = d;
        ifc.axi_wstrb  = s;
        ifc.axi_wlast  = last;
        while (!ifc.axi_wready && n < TMO) begin tick(); n++; end
        if (n >= TMO) timeout("w");
        tick();
        ifc.axi_wvalid = 1'b0;
        ifc.axi_wlast  = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp);
        int n = 0;
        ifc.axi_bready = 1'b1;
        while (!ifc.axi_bvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) timeout("b");
        resp = ifc.axi_bresp;
        tick();
        ifc.axi_bready = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len);
        int n = 0;
        ifc.axi_arvalid = 1'b1;
        ifc.axi_araddr  = a;
        ifc.axi_arlen   = len;
        while (!ifc.axi_arready && n < TMO) begin tick(); n++; end
        if (n >= TMO) timeout("ar");
        tick();
        ifc.axi_arvalid = 1'b0;
    endtask

    task automatic do_r(output logic [31:0] d, output logic [1:0] resp, output logic last);
        int n = 0;
        ifc.axi_rready = 1'b1;
        while (!ifc.axi_rvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) timeout("r");
        d    = ifc.axi_rdata;
        resp = ifc.axi_rresp;
        last = ifc.axi_rlast;
        tick();
        ifc.axi_rready = 1'b0;
    endtask

    task automatic write_single(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [1:0] resp);
        do_aw(a, 8'd0);
        do_w(d, s, 1'b1);
        do_b(resp);
    endtask

    task automatic read_single(input logic [31:0] a, output logic [31:0] d,
                               output logic [1:0] resp, output logic last);
        do_ar(a, 8'd0);
        do_r(d, resp, last);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arready"}, 32'(ifc.axi_arready), 32'd1);
        check({tag, "_awready"}, 32'(ifc.axi_awready), 32'd1);
        check({tag, "_rvalid"},  32'(ifc.axi_rvalid),  32'd0);
        check({tag, "_rdata"},   ifc.axi_rdata,        32'd0);
        check({tag, "_rresp"},   32'(ifc.axi_rresp),   32'd0);
        check({tag, "_rlast"},   32'(ifc.axi_rlast),   32'd0);
        check({tag, "_wready"},  32'(ifc.axi_wready),  32'd0);
        check({tag, "_bvalid"},  32'(ifc.axi_bvalid),  32'd0);
        check({tag, "_bresp"},   32'(ifc.axi_bresp),   32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        int          n;

        n_total = 0;
        n_bad   = 0;

        vecs[0] = '{32'h8000_0020, 32'h1111_1111, 32'hAABB_CCDD, 4'b0100, 32'h11BB_1111, 2'b00};
        vecs[1] = '{32'h8000_0024, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 2'b00};
        vecs[2] = '{32'h8000_0028, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001, 32'hFFFF_FF00, 2'b00};
        vecs[3] = '{32'h8000_002C, 32'h0000_0000, 32'h1234_5678, 4'b1010, 32'h1200_5600, 2'b00};
        vecs[4] = '{32'h8000_3FFC, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2'b00};
        vecs[5] = '{32'h8000_4000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'h7FFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'h8000_0030, 32'h5555_AAAA, 32'hFFFF_FFFF, 4'b0000, 32'h5555_AAAA, 2'b00};

        reset = 1'b1;
        ifc.axi_arvalid = 1'b0; ifc.axi_araddr = '0; ifc.axi_arlen = '0; ifc.axi_rready = 1'b0;
        ifc.axi_awvalid = 1'b0; ifc.axi_awaddr = '0; ifc.axi_awlen = '0;
        ifc.axi_wvalid = 1'b0; ifc.axi_wdata = '0; ifc.axi_wstrb = '0; ifc.axi_wlast = 1'b0;
        ifc.axi_bready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("rst");

        // Preload four words with one exact-length burst.
        do_aw(32'h8000_0000, 8'd3);
        for (int i = 0; i < 4; i++) do_w(32'h1000_0001 * 32'(i + 1), 4'hF, i == 3);
        do_b(resp);
        check("preload_bresp", 32'(resp), 32'd0);

        // Single read with latency check.
        write_single(32'h8000_0010, 32'h1234_5678, 4'hF, resp);
        check("single_wr_bresp", 32'(resp), 32'd0);
        do_ar(32'h8000_0010, 8'd0);
        check("single_rvalid_wait", 32'(ifc.axi_rvalid), 32'd0);
        check("single_arready_busy", 32'(ifc.axi_arready), 32'd0);
        tick();
        check("single_rvalid", 32'(ifc.axi_rvalid), 32'd1);
        check("single_rdata", ifc.axi_rdata, 32'h1234_5678);
        check("single_rresp", 32'(ifc.axi_rresp), 32'd0);
        check("single_rlast", 32'(ifc.axi_rlast), 32'd1);
        ifc.axi_rready = 1'b1;
        tick();
        ifc.axi_rready = 1'b0;
        check("single_rvalid_done", 32'(ifc.axi_rvalid), 32'd0);

        // Table: init word, partial-strobe write, read back.
        for (int i = 0; i < 8; i++) begin
            write_single(vecs[i].addr, vecs[i].init, 4'hF, resp);
            check($sformatf("v%0d_init_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            write_single(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
            check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            read_single(vecs[i].addr, d, resp, last);
            check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            check($sformatf("v%0d_rlast", i), 32'(last), 32'd1);
        end

        // Burst read with a 3-cycle stall on beat 1; also proves no aliasing
        // from the out-of-range writes above.
        do_ar(32'h8000_0000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                n = 0;
                while (!ifc.axi_rvalid && n < TMO) begin tick(); n++; end
                if (n >= TMO) timeout("burst_stall_wait");
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check($sformatf("stall%0d_rvalid", s), 32'(ifc.axi_rvalid), 32'd1);
                    check($sformatf("stall%0d_rdata", s), ifc.axi_rdata, 32'h2000_0002);
                    check($sformatf("stall%0d_rlast", s), 32'(ifc.axi_rlast), 32'd0);
                end
            end
            do_r(d, resp, last);
            check($sformatf("burst%0d_rdata", i), d, 32'h1000_0001 * 32'(i + 1));
            check($sformatf("burst%0d_rresp", i), 32'(resp), 32'd0);
            check($sformatf("burst%0d_rlast", i), 32'(last), 32'(i == 3));
        end

        // wlast earlier than awlen.
        do_aw(32'h8000_0060, 8'd3);
        do_w(32'h0000_0011, 4'hF, 1'b0);
        do_w(32'h0000_0022, 4'hF, 1'b1);
        do_b(resp);
        check("early_bresp", 32'(resp), 32'd2);
        read_single(32'h8000_0064, d, resp, last);
        check("early_rdata", d, 32'h0000_0022);

        // wlast later than awlen.
        do_aw(32'h8000_0070, 8'd0);
        do_w(32'h0000_0033, 4'hF, 1'b0);
        do_w(32'h0000_0044, 4'hF, 1'b1);
        do_b(resp);
        check("late_bresp", 32'(resp), 32'd2);
        read_single(32'h8000_0074, d, resp, last);
        check("late_rdata", d, 32'h0000_0044);

        // Second beat crosses the top of memory: sticky error, first beat kept.
        do_aw(32'h8000_3FFC, 8'd1);
        do_w(32'h5A5A_5A5A, 4'hF, 1'b0);
        do_w(32'h0000_0066, 4'hF, 1'b1);
        do_b(resp);
        check("sticky_bresp", 32'(resp), 32'd2);
        read_single(32'h8000_3FFC, d, resp, last);
        check("sticky_rdata", d, 32'h5A5A_5A5A);
        check("sticky_rresp", 32'(resp), 32'd0);

        // Concurrent read and write bursts, then reset while read is stalled.
        ifc.axi_arvalid = 1'b1; ifc.axi_araddr = 32'h8000_0000; ifc.axi_arlen = 8'd3;
        ifc.axi_awvalid = 1'b1; ifc.axi_awaddr = 32'h8000_0050; ifc.axi_awlen = 8'd1;
        tick();
        ifc.axi_arvalid = 1'b0;
        ifc.axi_awvalid = 1'b0;
        check("conc_arready_busy", 32'(ifc.axi_arready), 32'd0);
        check("conc_awready_busy", 32'(ifc.axi_awready), 32'd0);
        do_w(32'h0000_0077, 4'hF, 1'b0);
        do_w(32'h0000_0088, 4'hF, 1'b1);
        do_b(resp);
        check("conc_bresp", 32'(resp), 32'd0);
        check("conc_rvalid", 32'(ifc.axi_rvalid), 32'd1);
        check("conc_rdata", ifc.axi_rdata, 32'h1000_0001);
        reset = 1'b1;
        tick();
        check_idle_outputs("midrst");
        reset = 1'b0;
        read_single(32'h8000_0054, d, resp, last);
        check("retained_wr", d, 32'h0000_0088);
        read_single(32'h8000_0000, d, resp, last);
        check("retained_mem0", d, 32'h1000_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
